// File: rtl/sgmii_rx_aligner.sv
// SGMII receive comma aligner: hunts for a comma, locks the 10-bit symbol phase,
// runs the sync state machine and hands aligned symbols to the 8b10b decoder.
module sgmii_rx_aligner #(
   parameter logic [9:0]  COMMA_P     = 10'b0011111010,
   parameter logic [9:0]  COMMA_N     = 10'b1100000101,
   parameter logic [9:0]  COMMA_MASK  = 10'b1111111000,
   parameter int unsigned SYNC_COMMAS = 3,
   parameter int unsigned ERR_LIMIT   = 4,
   parameter int unsigned GOOD_WORDS  = 4
) (
   input  logic       ser_sgmii_clk,
   input  logic       reset,
   input  logic       sgmii_rx_p,
   input  logic       sgmii_rx_n,
   output logic [9:0] word_out,
   output logic       word_valid,
   output logic       word_is_comma,
   output logic       sym_err,
   output logic       sync
);

   // state          | meaning
   // LOSS_OF_SYNC   | hunting for a comma at any bit offset, phase free-running
   // COMMA_DETECT   | phase locked, counting aligned commas toward sync
   // SYNC_ACQUIRED  | emitting one word per 10 bits, tracking the error budget
   typedef enum logic [1:0] {
      LOSS_OF_SYNC  = 2'd0,
      COMMA_DETECT  = 2'd1,
      SYNC_ACQUIRED = 2'd2
   } state_t;

   localparam logic [3:0] SYNC_COMMAS_C = 4'(SYNC_COMMAS);
   localparam logic [3:0] ERR_LIMIT_C   = 4'(ERR_LIMIT);
   localparam logic [3:0] GOOD_WORDS_C  = 4'(GOOD_WORDS);

   state_t     state_q, state_d;
   logic [9:0] w_q, w_d;
   logic [3:0] ph_q, ph_d;
   logic [3:0] comma_cnt_q, comma_cnt_d;
   logic [3:0] err_cnt_q, err_cnt_d;
   logic [3:0] good_cnt_q, good_cnt_d;
   logic       word_err_q, word_err_d;
   logic       mis_q, mis_d;
   logic [9:0] word_out_q, word_out_d;
   logic       word_valid_q, word_valid_d;
   logic       word_is_comma_q, word_is_comma_d;
   logic       sym_err_q, sym_err_d;
   logic       sync_q, sync_d;

   logic comma_match;
   logic boundary;
   logic bit_err;
   logic bad_word;
   logic los_hit;
   logic word_clr;

   assign comma_match = ((w_q & COMMA_MASK) == (COMMA_P & COMMA_MASK)) ||
                        ((w_q & COMMA_MASK) == (COMMA_N & COMMA_MASK));
   assign boundary    = (ph_q == 4'd9);
   assign bit_err     = (sgmii_rx_p == sgmii_rx_n);
   assign bad_word    = word_err_q | mis_q;
   assign los_hit     = (state_q == LOSS_OF_SYNC) && comma_match;
   // A comma caught while hunting starts a fresh word exactly like a boundary does.
   assign word_clr    = boundary | los_hit;

   always_ff @(posedge ser_sgmii_clk or negedge reset) begin
      if (!reset) begin
         state_q         <= LOSS_OF_SYNC;
         w_q             <= '0;
         ph_q            <= '0;
         comma_cnt_q     <= '0;
         err_cnt_q       <= '0;
         good_cnt_q      <= '0;
         word_err_q      <= 1'b0;
         mis_q           <= 1'b0;
         word_out_q      <= '0;
         word_valid_q    <= 1'b0;
         word_is_comma_q <= 1'b0;
         sym_err_q       <= 1'b0;
         sync_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         w_q             <= w_d;
         ph_q            <= ph_d;
         comma_cnt_q     <= comma_cnt_d;
         err_cnt_q       <= err_cnt_d;
         good_cnt_q      <= good_cnt_d;
         word_err_q      <= word_err_d;
         mis_q           <= mis_d;
         word_out_q      <= word_out_d;
         word_valid_q    <= word_valid_d;
         word_is_comma_q <= word_is_comma_d;
         sym_err_q       <= sym_err_d;
         sync_q          <= sync_d;
      end
   end

   always_comb begin
      w_d = {w_q[8:0], sgmii_rx_p};
      if (los_hit || boundary) begin
         ph_d = 4'd0;
      end else begin
         ph_d = ph_q + 4'd1;
      end
      word_err_d = (word_clr ? 1'b0 : word_err_q) | bit_err;
      // Once the phase is owned, a comma anywhere but the boundary spoils the word.
      mis_d = (word_clr ? 1'b0 : mis_q) |
              (comma_match && !boundary && (state_q != LOSS_OF_SYNC));
   end

   always_comb begin
      state_d     = state_q;
      comma_cnt_d = comma_cnt_q;
      err_cnt_d   = err_cnt_q;
      good_cnt_d  = good_cnt_q;
      case (state_q)
         LOSS_OF_SYNC: begin
            if (comma_match) begin
               comma_cnt_d = 4'd1;
               if (SYNC_COMMAS_C == 4'd1) begin
                  state_d    = SYNC_ACQUIRED;
                  err_cnt_d  = '0;
                  good_cnt_d = '0;
               end else begin
                  state_d = COMMA_DETECT;
               end
            end
         end
         COMMA_DETECT: begin
            if (boundary) begin
               if (bad_word) begin
                  state_d     = LOSS_OF_SYNC;
                  comma_cnt_d = '0;
               end else if (comma_match) begin
                  comma_cnt_d = comma_cnt_q + 4'd1;
                  if ((comma_cnt_q + 4'd1) == SYNC_COMMAS_C) begin
                     state_d    = SYNC_ACQUIRED;
                     err_cnt_d  = '0;
                     good_cnt_d = '0;
                  end
               end
            end
         end
         SYNC_ACQUIRED: begin
            if (boundary) begin
               if (bad_word) begin
                  good_cnt_d = '0;
                  err_cnt_d  = err_cnt_q + 4'd1;
                  if ((err_cnt_q + 4'd1) == ERR_LIMIT_C) begin
                     state_d   = LOSS_OF_SYNC;
                     err_cnt_d = '0;
                  end
               end else begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if ((good_cnt_q + 4'd1) == GOOD_WORDS_C) begin
                     err_cnt_d  = '0;
                     good_cnt_d = '0;
                  end
               end
            end
         end
         default: begin
            state_d = LOSS_OF_SYNC;
         end
      endcase
   end

   // A word is emitted whenever the boundary leaves us in (or brings us into) sync.
   always_comb begin
      word_out_d      = word_out_q;
      word_is_comma_d = word_is_comma_q;
      sym_err_d       = sym_err_q;
      word_valid_d    = 1'b0;
      sync_d          = (state_d == SYNC_ACQUIRED);
      if ((state_d == SYNC_ACQUIRED) && ((state_q != SYNC_ACQUIRED) || boundary)) begin
         word_valid_d    = 1'b1;
         word_out_d      = w_q;
         word_is_comma_d = comma_match;
         sym_err_d       = (state_q == SYNC_ACQUIRED) && bad_word;
      end
   end

   assign word_out      = word_out_q;
   assign word_valid    = word_valid_q;
   assign word_is_comma = word_is_comma_q;
   assign sym_err       = sym_err_q;
   assign sync          = sync_q;

endmodule
